seq_alu: RTL

- Clocked, parametrised successor to the CPU's combinational ALU.
- Executes one operation per start handshake and holds the carry flag and the multiply high-word register internally.
- Replaces the exec2-driven external multiplier path with an internal iterative signed shift-add multiplier.
- Sits between the register file and the writeback mux; the decoder drives start and op, and waits on done.

---
 rtl/seq_alu.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus an iterative signed
// shift-add multiplier (MUL/MLA) that leaves its high word in an internal register.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal
);
  localparam logic [5:0] OP_AND = 6'b001100, OP_OR  = 6'b001101, OP_XOR = 6'b001110,
                         OP_NOT = 6'b001111, OP_NND = 6'b010000, OP_NOR = 6'b010001,
                         OP_XNR = 6'b010010, OP_MOV = 6'b010011, OP_ADD = 6'b010100,
                         OP_ADC = 6'b010101, OP_ADO = 6'b010110, OP_SUB = 6'b011000,
                         OP_SBC = 6'b011001, OP_SBO = 6'b011010, OP_MUL = 6'b011100,
                         OP_MLA = 6'b011101, OP_MRT = 6'b011111, OP_LSL = 6'b100000,
                         OP_LSR = 6'b100001, OP_ASR = 6'b100010, OP_ROR = 6'b100100;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, c_q, c_d;
  logic               carry_q, carry_d, zero_q, zero_d, done_q, done_d, ill_q, ill_d;
  logic               sign_q, sign_d, mla_q, mla_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH:0]     mplier_q, mplier_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  // single-cycle datapath
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_wc, alu_ok;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] rot2;
  logic [SHW-1:0]     sh;
  logic               big;

  assign sh   = b[SHW-1:0];
  assign big  = |b[WIDTH-1:SHW];
  assign rot2 = {a, a} >> sh;

  always_comb begin
    alu_res = result_q;
    alu_c   = carry_q;
    alu_wc  = 1'b0;
    alu_ok  = 1'b1;
    sum     = '0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_NND: alu_res = ~(a & b);
      OP_NOR: alu_res = ~(a | b);
      OP_XNR: alu_res = ~(a ^ b);
      OP_MOV: alu_res = a;
      OP_ADD, OP_ADC, OP_ADO, OP_SUB, OP_SBC, OP_SBO: begin
        case (op)
          OP_ADD:  sum = {1'b0, a} + {1'b0, b};
          OP_ADC:  sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(carry_q);
          OP_ADO:  sum = {1'b0, a} + (WIDTH+1)'(1);
          OP_SUB:  sum = {1'b0, a} - {1'b0, b};
          OP_SBC:  sum = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(carry_q);
          default: sum = {1'b0, a} - (WIDTH+1)'(1);
        endcase
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_wc  = 1'b1;
      end
      OP_LSL: alu_res = big ? '0 : a << sh;
      OP_LSR: alu_res = big ? '0 : a >> sh;
      OP_ASR: alu_res = big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> sh);
      OP_ROR: alu_res = rot2[WIDTH-1:0];
      OP_MRT: alu_res = hi_q;
      default: alu_ok = 1'b0;
    endcase
  end

  // magnitudes need WIDTH+1 bits so the most-negative operand stays exact
  logic [WIDTH:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0] prod;

  assign abs_a = a[WIDTH-1] ? ({1'b0, ~a} + (WIDTH+1)'(1)) : {1'b0, a};
  assign abs_b = b[WIDTH-1] ? ({1'b0, ~b} + (WIDTH+1)'(1)) : {1'b0, b};

  always_comb begin
    prod = sign_q ? -acc_q : acc_q;
    if (mla_q) prod = prod + {{WIDTH{c_q[WIDTH-1]}}, c_q};
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    done_d   = 1'b0;
    ill_d    = 1'b0;
    sign_d   = sign_q;
    mla_d    = mla_q;
    c_d      = c_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (op == OP_MUL || op == OP_MLA) begin
          mcand_d  = (2*WIDTH)'(abs_a);
          mplier_d = abs_b;
          sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
          mla_d    = (op == OP_MLA);
          c_d      = c;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          done_d = 1'b1;
          if (alu_ok) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            if (alu_wc) carry_d = alu_c;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = prod[WIDTH-1:0];
        hi_d     = prod[2*WIDTH-1:WIDTH];
        zero_d   = (prod[WIDTH-1:0] == '0);
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
      sign_q   <= 1'b0;
      mla_q    <= 1'b0;
      c_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      done_q   <= done_d;
      ill_q    <= ill_d;
      sign_q   <= sign_d;
      mla_q    <= mla_d;
      c_q      <= c_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result  = result_q;
  assign carry   = carry_q;
  assign zero    = zero_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign illegal = ill_q;
endmodule
